// File: rtl/spis_byte.sv
// spis_byte: SPI target byte engine on an oversampled 1/2/4-bit bus.
// Define SPIS_BCNT_EN to add bcnt, a per-frame completed-byte counter.
module spis_byte #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL        = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] bmode,
  input  logic       bdir,
  input  logic [7:0] tbyte,
  input  logic       tvalid,
  output logic       tready,
  output logic [7:0] rbyte,
  output logic       rvalid,
  output logic       underrun,
  output logic       frame,
`ifdef SPIS_BCNT_EN
  output logic [7:0] bcnt,
`endif
  input  logic       spi_ck,
  input  logic       spi_cs_n,
  input  logic [3:0] spi_di,
  output logic [3:0] spi_do,
  output logic [3:0] spi_oe
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0]      ck_s_q, ck_s_d;
  logic [SYNC_STAGES-1:0]      cs_s_q, cs_s_d;
  logic [SYNC_STAGES-1:0][3:0] di_s_q, di_s_d;
  logic       ck_p_q, cs_p_q;
  logic       ck_now, cs_now;
  logic [3:0] di_now, di_m;
  logic       ck_rise, ck_fall, cs_rise, cs_fall;

  logic [1:0] mode_q, mode_d, new_mode;
  logic       dir_q, dir_d;
  logic [3:0] cnt_q, cnt_d, cnt_n;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d, rx_n;
  logic [7:0] rbyte_q, rbyte_d, nxt_byte;
  logic [3:0] do_q, do_d, oe_q, oe_d;
  logic       smp_q, smp_d;
  logic       rvalid_q;
  logic       ld, done, rx_on;

  function automatic logic [3:0] wid(input logic [1:0] m);
    unique case (m)
      2'b01:   wid = 4'd2;
      2'b10:   wid = 4'd4;
      default: wid = 4'd1;
    endcase
  endfunction

  function automatic logic drives(input logic [1:0] m, input logic d);
    drives = (m == 2'b00) || d;
  endfunction

  function automatic logic [3:0] oe_of(input logic [1:0] m, input logic d);
    unique case (m)
      2'b01:   oe_of = d ? 4'b0011 : 4'b0000;
      2'b10:   oe_of = d ? 4'b1111 : 4'b0000;
      default: oe_of = 4'b0010;
    endcase
  endfunction

  // group still to send once the counter stands at c, aligned to its lanes
  function automatic logic [3:0] grp(input logic [7:0] b,
                                     input logic [3:0] c,
                                     input logic [1:0] m);
    logic [3:0] s;
    s = 4'(b >> (c - wid(m)));
    unique case (m)
      2'b01:   grp = {2'b00, s[1:0]};
      2'b10:   grp = s;
      default: grp = {2'b00, s[0], 1'b0};
    endcase
  endfunction

  assign ck_s_d = {ck_s_q[SYNC_STAGES-2:0], spi_ck};
  assign cs_s_d = {cs_s_q[SYNC_STAGES-2:0], spi_cs_n};
  assign di_s_d = {di_s_q[SYNC_STAGES-2:0], spi_di};

  assign ck_now  = ck_s_q[SYNC_STAGES-1];
  assign cs_now  = cs_s_q[SYNC_STAGES-1];
  assign di_now  = di_s_q[SYNC_STAGES-1];
  assign ck_rise = ck_now & ~ck_p_q;
  assign ck_fall = ~ck_now & ck_p_q;
  assign cs_rise = cs_now & ~cs_p_q;
  assign cs_fall = ~cs_now & cs_p_q;

  assign new_mode = (bmode == 2'b11) ? 2'b00 : bmode;
  assign nxt_byte = tvalid ? tbyte : FILL;
  assign rx_on    = (mode_q == 2'b00) || !dir_q;

  always_comb begin
    unique case (mode_q)
      2'b01:   di_m = {2'b00, di_now[1:0]};
      2'b10:   di_m = di_now;
      default: di_m = {3'b000, di_now[0]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rbyte_d = rbyte_q;
    do_d    = do_q;
    oe_d    = oe_q;
    smp_d   = smp_q;
    ld      = 1'b0;
    done    = 1'b0;
    cnt_n   = cnt_q - wid(mode_q);
    rx_n    = (rx_q << wid(mode_q)) | {4'h0, rx_on ? di_m : 4'h0};
    unique case (state_q)
      IDLE: begin
        oe_d = 4'h0;
        do_d = 4'h0;
        if (cs_fall) state_d = LOAD;
      end
      LOAD: begin
        if (cs_rise) begin
          state_d = IDLE;
          oe_d    = 4'h0;
          do_d    = 4'h0;
        end else begin
          ld      = 1'b1;
          state_d = SHIFT;
          mode_d  = new_mode;
          dir_d   = bdir;
          cnt_d   = 4'd8;
          tx_d    = nxt_byte;
          rx_d    = 8'h00;
          smp_d   = 1'b0;
          oe_d    = oe_of(new_mode, bdir);
          do_d    = drives(new_mode, bdir) ?
                    grp(nxt_byte, 4'd8, new_mode) : 4'h0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          oe_d    = 4'h0;
          do_d    = 4'h0;
        end else if (ck_rise) begin
          smp_d = 1'b1;
          if (cnt_n == 4'd0) begin
            done    = 1'b1;
            ld      = 1'b1;
            rbyte_d = rx_n;
            rx_d    = 8'h00;
            mode_d  = new_mode;
            dir_d   = bdir;
            cnt_d   = 4'd8;
            tx_d    = nxt_byte;
            oe_d    = oe_of(new_mode, bdir);
          end else begin
            rx_d  = rx_n;
            cnt_d = cnt_n;
          end
        end else if (ck_fall && smp_q) begin
          // a fall before any rise (mode 3) keeps the preloaded group
          smp_d = 1'b0;
          do_d  = drives(mode_q, dir_q) ?
                  grp(tx_q, cnt_q, mode_q) : 4'h0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // cs chain resets low so a frame already open at reset is never joined
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ck_s_q   <= '0;
      cs_s_q   <= '0;
      di_s_q   <= '0;
      ck_p_q   <= 1'b0;
      cs_p_q   <= 1'b0;
      mode_q   <= 2'b00;
      dir_q    <= 1'b0;
      cnt_q    <= 4'd0;
      tx_q     <= 8'h00;
      rx_q     <= 8'h00;
      rbyte_q  <= 8'h00;
      do_q     <= 4'h0;
      oe_q     <= 4'h0;
      smp_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ck_s_q   <= ck_s_d;
      cs_s_q   <= cs_s_d;
      di_s_q   <= di_s_d;
      ck_p_q   <= ck_now;
      cs_p_q   <= cs_now;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rbyte_q  <= rbyte_d;
      do_q     <= do_d;
      oe_q     <= oe_d;
      smp_q    <= smp_d;
      rvalid_q <= done;
    end
  end

`ifdef SPIS_BCNT_EN
  logic [7:0] bcnt_q, bcnt_d;

  always_comb begin
    bcnt_d = bcnt_q;
    if (state_q == LOAD && !cs_rise) bcnt_d = 8'h00;
    else if (done && bcnt_q != 8'hFF) bcnt_d = bcnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) bcnt_q <= 8'h00;
    else     bcnt_q <= bcnt_d;
  end

  assign bcnt = bcnt_q;
`endif

  assign tready   = ld & tvalid & ~rst;
  assign underrun = ld & ~tvalid & ~rst;
  assign rbyte    = rbyte_q;
  assign rvalid   = rvalid_q;
  assign frame    = (state_q != IDLE) & ~cs_rise;
  assign spi_do   = do_q;
  assign spi_oe   = oe_q & {4{~cs_rise}};

endmodule
